// File: rtl/fft_uart_tx_packer.sv
// Pulls FFT result points one by one and ships each as 8 UART 8N1 bytes (re then im, LSB first).
// Define FFT_TX_HEADER_EN to prefix every frame with the sync bytes 0xAA, 0x55.
module fft_uart_tx_packer #(
  parameter int t_1_bit   = 5207,
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 out_valid,
  input  logic [bit_width-1:0] data_re,
  input  logic [bit_width-1:0] data_im,
  output logic                 en_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int BAUD_W = (t_1_bit > 1) ? $clog2(t_1_bit) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(t_1_bit - 1);
  localparam logic [SIZE-1:0]   PT_LAST   = SIZE'(N - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE
  } state_t;

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_reg;
  logic [2:0]        byte_reg;
  logic [SIZE-1:0]   pt_reg;
  logic [63:0]       buf_reg;
  logic [7:0]        sh_reg;
  logic [31:0]       re_ext;
  logic [31:0]       im_ext;
  logic              baud_end;
`ifdef FFT_TX_HEADER_EN
  logic              hdr_reg;
`endif

  for (genvar gi = 0; gi < 32; gi++) begin : g_sext
    localparam int SRC = (gi < bit_width) ? gi : bit_width - 1;
    assign re_ext[gi] = data_re[SRC];
    assign im_ext[gi] = data_im[SRC];
  end

  assign baud_end = (baud_reg == BAUD_LAST);

  // LOAD is the first clk of every start bit, so tx drops on entry and the baud counter resumes at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      byte_reg   <= '0;
      pt_reg     <= '0;
      buf_reg    <= '0;
      sh_reg     <= '0;
      tx         <= 1'b1;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
`ifdef FFT_TX_HEADER_EN
      hdr_reg    <= 1'b0;
`endif
    end else begin
      en_out     <= 1'b0;
      frame_done <= 1'b0;
      if (out_valid && state_reg != WAIT_DATA) overflow <= 1'b1;
      case (state_reg)
        IDLE: begin
          pt_reg   <= '0;
          byte_reg <= '0;
          baud_reg <= '0;
          if (start) begin
            busy <= 1'b1;
`ifdef FFT_TX_HEADER_EN
            hdr_reg   <= 1'b1;
            buf_reg   <= {48'd0, 16'h55AA};
            tx        <= 1'b0;
            state_reg <= LOAD;
`else
            en_out    <= 1'b1;
            state_reg <= REQ;
`endif
          end
        end
        REQ: state_reg <= WAIT_DATA;
        WAIT_DATA: begin
          if (out_valid) begin
            buf_reg   <= {im_ext, re_ext};
            tx        <= 1'b0;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          sh_reg    <= buf_reg[7:0];
          buf_reg   <= {8'd0, buf_reg[63:8]};
          baud_reg  <= BAUD_W'(1);
          state_reg <= START_BIT;
        end
        START_BIT: begin
          if (baud_end) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            tx        <= sh_reg[0];
            sh_reg    <= {1'b0, sh_reg[7:1]};
            state_reg <= DATA_BITS;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA_BITS: begin
          if (baud_end) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
              tx        <= 1'b1;
              state_reg <= STOP_BIT;
            end else begin
              bit_reg <= bit_reg + 1'b1;
              tx      <= sh_reg[0];
              sh_reg  <= {1'b0, sh_reg[7:1]};
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        STOP_BIT: begin
          if (baud_end) begin
            baud_reg <= '0;
`ifdef FFT_TX_HEADER_EN
            if (hdr_reg && byte_reg == 3'd1) begin
              hdr_reg   <= 1'b0;
              byte_reg  <= '0;
              en_out    <= 1'b1;
              state_reg <= REQ;
            end else
`endif
            if (byte_reg != 3'd7) begin
              byte_reg  <= byte_reg + 1'b1;
              tx        <= 1'b0;
              state_reg <= LOAD;
            end else if (pt_reg != PT_LAST) begin
              pt_reg    <= pt_reg + 1'b1;
              byte_reg  <= '0;
              en_out    <= 1'b1;
              state_reg <= REQ;
            end else begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state_reg  <= DONE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DONE: begin
          pt_reg    <= '0;
          byte_reg  <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
